alu_issue_ctrl: RTL and testbench

Request/response front end for the registered 32-bit ALU. Accepts one operation at a time over a valid/ready request channel and drives the ALU's operand and opcode inputs. Captures the ALU's registered result and zero flag, then returns them with a tag over a valid/ready response channel. Sits between an instruction sequencer or testbench master and the ALU, and keeps a running count of completed operations.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: opcode values, idle opcode, FSM states.
// Opcodes 0..9 are real ALU operations; anything above is unused and makes the ALU output 0.
// 4'hF is driven whenever no operation is being issued so the ALU sits at a known result.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // True for opcodes the ALU actually implements.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Request/response wrapper around the registered 32-bit ALU, one operation in flight at a time.
// Latency: response valid 3 cycles after acceptance (1 cycle for rejected opcodes with ALU_ISSUE_OPCHK_EN).
// Backpressure: response held stable until rsp_ready; no new request accepted until the response drains.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_in0,
  output logic [31:0]      alu_in1,
  output logic [3:0]       control_signal,
  input  logic [31:0]      alu_out,
  input  logic             zero_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        req_fire;
  logic        rsp_fire;
  logic        op_reject;

  assign req_fire = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

`ifdef ALU_ISSUE_OPCHK_EN
  assign op_reject = ~op_is_legal(req_op);
`else
  assign op_reject = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: rejected opcodes skip the ALU and go straight to the response.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_fire) state_nxt = op_reject ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_fire) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; the ALU sees operands only while issuing.
  always_comb begin
    req_ready      = (state == ST_IDLE);
    rsp_valid      = (state == ST_RESP);
    busy           = (state != ST_IDLE);
    alu_in0        = '0;
    alu_in1        = '0;
    control_signal = OP_IDLE;
    if (state == ST_ISSUE) begin
      alu_in0        = a_q;
      alu_in1        = b_q;
      control_signal = op_q;
    end
  end

  // Request latch and response capture; a rejected opcode preloads the canned error response.
  always_ff @(posedge clk) begin
    if (clear) begin
      op_q       <= OP_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (req_fire) begin
      op_q    <= req_op;
      a_q     <= req_a;
      b_q     <= req_b;
      rsp_tag <= req_tag;
      if (op_reject) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b1;
      end
    end else if (state == ST_CAPTURE) begin
      rsp_result <= alu_out;
      rsp_zero   <= zero_flag;
    end
  end

`ifdef ALU_ISSUE_OPCHK_EN
  // Error flag follows the opcode check of the accepted request.
  always_ff @(posedge clk) begin
    if (clear)         rsp_err <= 1'b0;
    else if (req_fire) rsp_err <= op_reject;
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (clear)         op_count <= '0;
    else if (rsp_fire) op_count <= op_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural registered ALU attached.
// Honours ALU_ISSUE_OPCHK_EN when computing the expected error responses.
module tb_alu_issue_ctrl;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;
`ifdef ALU_ISSUE_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_op = 4'd0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      alu_in0;
  logic [31:0]      alu_in1;
  logic [3:0]       control_signal;
  logic [31:0]      alu_out = '0;
  logic             zero_flag = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  alu_issue_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .control_signal(control_signal),
    .alu_out(alu_out), .zero_flag(zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU semantics straight from the opcode list.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // The registered ALU the block drives.
  always @(posedge clk) begin
    alu_out   <= ref_alu(control_signal, alu_in0, alu_in1);
    zero_flag <= (ref_alu(control_signal, alu_in0, alu_in1) == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge, wait for the response, hold off for 'hold' cycles, then drain it.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] exp_res, input logic exp_zero, input int hold);
    bit err;
    int lat;
    err = OPCHK && (op >= 4'hA);
    chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom; req_tag = 4'($urandom);
    lat = 1;
    if (err) begin
      chk({name, ".ctl_idle"}, {28'd0, control_signal}, 32'hF);
    end else begin
      chk({name, ".ctl"}, {28'd0, control_signal}, {28'd0, op});
      chk({name, ".in0"}, alu_in0, a);
      chk({name, ".in1"}, alu_in1, b);
    end
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, lat, err ? 1 : 3);
    for (int h = 0; h <= hold; h++) begin
      chk({name, ".result"}, rsp_result, exp_res);
      chk({name, ".zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
      chk({name, ".tag"}, {28'd0, rsp_tag}, {28'd0, tag});
      chk({name, ".err"}, {31'd0, rsp_err}, {31'd0, err});
      if (hold > 0) begin
        chk({name, ".bp_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({name, ".bp_cnt"}, {16'd0, op_count}, exp_cnt[15:0]);
      end
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk({name, ".drain_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({name, ".count"}, {16'd0, op_count}, exp_cnt[15:0]);
    chk({name, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        zero;
    int          hold;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int starts[$];
    int rsp_seen;
    int bad;
    logic [3:0]  op;
    logic [31:0] a, b;

    tbl[0]  = '{4'd0, 32'd5,          32'd7,          4'd3, 32'd12,         1'b0, 0};
    tbl[1]  = '{4'd1, 32'd9,          32'd9,          4'd1, 32'd0,          1'b1, 5};
    tbl[2]  = '{4'd7, 32'h8000_0000,  32'd4,          4'd2, 32'hF800_0000,  1'b0, 0};
    tbl[3]  = '{4'd9, 32'hFFFF_FFFF,  32'd1,          4'd4, 32'd1,          1'b0, 1};
    tbl[4]  = '{4'd8, 32'hFFFF_FFFF,  32'd1,          4'd5, 32'd0,          1'b1, 0};
    tbl[5]  = '{4'd2, 32'hF0F0_00FF,  32'h0FF0_0F0F,  4'd6, 32'h00F0_000F,  1'b0, 0};
    tbl[6]  = '{4'd3, 32'h1200_0000,  32'h0000_0034,  4'd7, 32'h1200_0034,  1'b0, 2};
    tbl[7]  = '{4'd4, 32'hAAAA_5555,  32'hFFFF_0000,  4'd8, 32'h5555_5555,  1'b0, 0};
    tbl[8]  = '{4'd5, 32'd1,          32'd31,         4'd9, 32'h8000_0000,  1'b0, 0};
    tbl[9]  = '{4'd6, 32'h8000_0000,  32'd31,         4'hA, 32'd1,          1'b0, 0};
    tbl[10] = '{4'hC, 32'd123,        32'd456,        4'hE, 32'd0,          1'b1, 0};
    tbl[11] = '{4'hF, 32'd77,         32'd88,         4'hF, 32'd0,          1'b1, 1};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.result", rsp_result, 32'd0);
    chk("rst.zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst.tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst.err", {31'd0, rsp_err}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.count", {16'd0, op_count}, 32'd0);
    chk("rst.in0", alu_in0, 32'd0);
    chk("rst.in1", alu_in1, 32'd0);
    chk("rst.ctl", {28'd0, control_signal}, 32'hF);

    // Directed vectors.
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].res, tbl[i].zero, tbl[i].hold);

    // rsp_ready while no response is pending does nothing.
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_ready.count", {16'd0, op_count}, exp_cnt[15:0]);
    chk("idle_ready.valid", {31'd0, rsp_valid}, 32'd0);

    // Clear during CAPTURE discards the operation.
    req_valid = 1'b1; req_op = 4'd0; req_a = 32'd1; req_b = 32'd2; req_tag = 4'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("clr.busy", {31'd0, busy}, 32'd0);
    chk("clr.valid", {31'd0, rsp_valid}, 32'd0);
    chk("clr.ctl", {28'd0, control_signal}, 32'hF);
    clear = 1'b0;
    exp_cnt = 0;
    chk("clr.req_ready", {31'd0, req_ready}, 32'd1);
    bad = 0;
    rsp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    rsp_ready = 1'b0;
    chk("clr.no_rsp", bad, 0);
    chk("clr.count", {16'd0, op_count}, 32'd0);

    // Throughput with rsp_ready held high: one acceptance every 4 cycles.
    rsp_seen = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'd0; req_a = 32'd3; req_b = 32'd4; req_tag = 4'd1;
    for (int i = 0; i < 14; i++) begin
      if (req_ready) starts.push_back(i);
      if (rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) begin
      if (rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    if (starts.size() >= 3) begin
      chk("tput.gap1", starts[1] - starts[0], 4);
      chk("tput.gap2", starts[2] - starts[1], 4);
    end else begin
      chk("tput.starts", starts.size(), 3);
    end
    exp_cnt = (exp_cnt + rsp_seen) % 65536;
    chk("tput.rsp_count", rsp_seen, 4);
    chk("tput.count", {16'd0, op_count}, exp_cnt[15:0]);

    // Randomized operations against the reference semantics.
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      run_op($sformatf("rnd%0d", i), op, a, b, 4'($urandom), ref_alu(op, a, b),
             ref_alu(op, a, b) == 32'd0, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
